// File: rtl/multicycle_adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle ripple adder.
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nstep(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic bit params_legal(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

    // A one-step adder still needs a one-bit counter to keep the datapath legal.
    function automatic int cnt_width(input int nstep);
        return (nstep > 1) ? $clog2(nstep) : 1;
    endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Producer/consumer handshake bundle for multicycle_adder.
// The sub port exists only when MULTICYCLE_ADDER_SUB_EN is defined.
interface multicycle_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef MULTICYCLE_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

`ifdef MULTICYCLE_ADDER_SUB_EN
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
`else
    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );
    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
`endif

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/multicycle_adder_slice.sv
// Combinational DIGIT-bit ripple slice built from full_adder cells.
// Also exposes the carry into its MSB so the caller can derive signed overflow.
module digit_adder_slice #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_c,
    output logic [DIGIT-1:0] o_s,
    output logic             o_c,
    output logic             o_c_msb
);
    logic [DIGIT:0] w_c;

    assign w_c[0] = i_c;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            full_adder u_fa (
                .i_a (i_a[gi]),
                .i_b (i_b[gi]),
                .i_c (w_c[gi]),
                .o_s (o_s[gi]),
                .o_c (w_c[gi+1])
            );
        end
    endgenerate

    assign o_c     = w_c[DIGIT];
    assign o_c_msb = w_c[DIGIT-1];
endmodule

// File: rtl/multicycle_adder.sv
// WIDTH-bit adder that processes DIGIT bits per clock through one reused slice.
// Define MULTICYCLE_ADDER_SUB_EN to add a subtract mode (a + ~b + 1).
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_adder_if.slave     bus
);
    localparam int NSTEP = calc_nstep(WIDTH, DIGIT);
    localparam int CNT_W = cnt_width(NSTEP);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEP - 1);

    generate
        if (!params_legal(WIDTH, DIGIT)) begin : g_param_check
            $error("multicycle_adder: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_c_last;
    logic             r_ovf_last;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_out_valid;

    logic [DIGIT-1:0] w_dig_s;
    logic             w_dig_co;
    logic             w_dig_cmsb;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;
    logic             w_publish;
    logic             w_release;
    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_init;

`ifdef MULTICYCLE_ADDER_SUB_EN
    assign w_sub = bus.sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_b_eff  = w_sub ? ~bus.b : bus.b;
    assign w_c_init = w_sub ? 1'b1 : bus.c_in;

    assign w_accept  = w_in_ready && bus.in_valid;
    assign w_last    = (r_cnt == LAST_STEP);
    assign w_publish = (r_state == DONE) && !r_out_valid;
    assign w_release = r_out_valid && bus.out_ready;

    digit_adder_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .i_a     (r_a[DIGIT-1:0]),
        .i_b     (r_b[DIGIT-1:0]),
        .i_c     (r_carry),
        .o_s     (w_dig_s),
        .o_c     (w_dig_co),
        .o_c_msb (w_dig_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (w_release) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operands shift right so the slice always sees digit 0; finished digits
    // enter the accumulator from the top and end up in place after NSTEP steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_c_last    <= 1'b0;
            r_ovf_last  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_b_eff;
            r_carry <= w_c_init;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_acc   <= (r_acc >> DIGIT) | (WIDTH'(w_dig_s) << (WIDTH - DIGIT));
            r_carry <= w_dig_co;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_c_last   <= w_dig_co;
                r_ovf_last <= w_dig_co ^ w_dig_cmsb;
            end
        end
    end

    // Result registers update once per operation and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_publish) begin
            r_sum       <= r_acc;
            r_c_out     <= r_c_last;
            r_ovf       <= r_ovf_last;
            r_out_valid <= 1'b1;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.c_out     = r_c_out;
    assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed-vector bench for multicycle_adder (32/8 main instance, 8/8 single-step instance).
// Subtract vectors run only when MULTICYCLE_ADDER_SUB_EN is defined.
module tb_multicycle_adder;
    localparam int WIDTH = 32;
    localparam int DIGIT = 8;
    localparam int NSTEP = WIDTH / DIGIT;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multicycle_adder_if #(.WIDTH(WIDTH)) bus ();
    multicycle_adder_if #(.WIDTH(8))     bus8 ();

    multicycle_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    multicycle_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [31:0] exp_sum,
                          input logic exp_co, input logic exp_ov);
        int lat;
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check_eq({tag, "/in_ready_before"}, 64'(bus.in_ready), 64'(1));
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = cin;
`ifdef MULTICYCLE_ADDER_SUB_EN
        bus.sub      = sub;
`endif
        bus.in_valid = 1'b1;
        tick();
        // Scramble operands after accept; they must not affect the result.
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = 32'h5A5A_A5A5;
        bus.c_in     = ~cin;
`ifdef MULTICYCLE_ADDER_SUB_EN
        bus.sub      = ~sub;
`endif
        check_eq({tag, "/in_ready_busy"}, 64'(bus.in_ready), 64'(0));
        wait_valid(lat);
        check_eq({tag, "/latency"}, 64'(lat), 64'(NSTEP + 1));
        check_eq({tag, "/sum"},      64'(bus.sum),      64'(exp_sum));
        check_eq({tag, "/c_out"},    64'(bus.c_out),    64'(exp_co));
        check_eq({tag, "/overflow"}, 64'(bus.overflow), 64'(exp_ov));
        check_eq({tag, "/in_ready_done"}, 64'(bus.in_ready), 64'(0));
        $display("op %s: a=%08h b=%08h cin=%0d sub=%0d -> sum=%08h c_out=%0d ovf=%0d lat=%0d",
                 tag, a, b, cin, sub, bus.sum, bus.c_out, bus.overflow, lat);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq({tag, "/out_valid_after"}, 64'(bus.out_valid), 64'(0));
        check_eq({tag, "/in_ready_after"},  64'(bus.in_ready),  64'(1));
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.c_in      = 1'b0;
        bus8.out_ready = 1'b0;
`ifdef MULTICYCLE_ADDER_SUB_EN
        bus.sub  = 1'b0;
        bus8.sub = 1'b0;
`endif

        #2 rst_n = 1'b0;
        #1;
        check_eq("reset/in_ready",  64'(bus.in_ready),  64'(1));
        check_eq("reset/out_valid", 64'(bus.out_valid), 64'(0));
        check_eq("reset/sum",       64'(bus.sum),       64'(0));
        check_eq("reset/c_out",     64'(bus.c_out),     64'(0));
        check_eq("reset/overflow",  64'(bus.overflow),  64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        run_op("1p2",        32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        run_op("ripple",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("posovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("negovf",     32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        run_op("negneg",     32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op("mixed",      32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 32'h2222_2221, 1'b0, 1'b0);

`ifdef MULTICYCLE_ADDER_SUB_EN
        run_op("sub3m5",     32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub5m3",     32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        run_op("subovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op("sub0add",    32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0009, 1'b0, 1'b0);
`endif

        // Backpressure: result held while the producer keeps in_valid high.
        bus.a        = 32'h1234_5678;
        bus.b        = 32'h0FED_CBA9;
        bus.c_in     = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check_eq("bp/latency", 64'(lat), 64'(NSTEP + 1));
        bus.a        = 32'h0000_0001;
        bus.b        = 32'h0000_0001;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("bp/sum_hold",  64'(bus.sum),       64'(32'h2222_2221));
            check_eq("bp/in_ready",  64'(bus.in_ready),  64'(0));
            check_eq("bp/out_valid", 64'(bus.out_valid), 64'(1));
        end
        $display("op bp: held 10 cycles sum=%08h", bus.sum);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("bp/in_ready_release",  64'(bus.in_ready),  64'(1));
        check_eq("bp/out_valid_release", 64'(bus.out_valid), 64'(0));
        tick();
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check_eq("bp/second_latency", 64'(lat), 64'(NSTEP + 1));
        check_eq("bp/second_sum",     64'(bus.sum), 64'(32'h0000_0002));
        $display("op bp2: 1+1 -> sum=%08h lat=%0d", bus.sum, lat);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset during RUN at step 2 aborts the add.
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'h0000_0001;
        bus.c_in     = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("rst_run/in_ready",  64'(bus.in_ready),  64'(1));
        check_eq("rst_run/out_valid", 64'(bus.out_valid), 64'(0));
        check_eq("rst_run/sum",       64'(bus.sum),       64'(0));
        check_eq("rst_run/c_out",     64'(bus.c_out),     64'(0));
        $display("op rst_run: reset at step 2, sum=%08h out_valid=%0d", bus.sum, bus.out_valid);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_eq("rst_run/no_stale_valid", 64'(bus.out_valid), 64'(0));
        run_op("5p6", 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0, 32'h0000_000B, 1'b0, 1'b0);

        // Single-step configuration: DIGIT == WIDTH.
        bus8.a        = 8'hFF;
        bus8.b        = 8'h01;
        bus8.c_in     = 1'b0;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("w8/latency",  64'(lat),            64'(2));
        check_eq("w8/sum",      64'(bus8.sum),       64'(0));
        check_eq("w8/c_out",    64'(bus8.c_out),     64'(1));
        check_eq("w8/overflow", 64'(bus8.overflow),  64'(0));
        $display("op w8: a=ff b=01 -> sum=%02h c_out=%0d lat=%0d", bus8.sum, bus8.c_out, lat);
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        check_eq("w8/in_ready_after", 64'(bus8.in_ready), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
